seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; legal values are 8 to 64 and must be a power of two.
REQ-002 SHALL have parameter IMM_W, default 16, immediate width; IMM_W <= WIDTH.
REQ-003 SHALL have parameter MUL_RADIX_BITS, default 1, multiplier bits consumed per iteration; legal values 1, 2, 4.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-005 Port clk, input, 1, rising-edge clock.
REQ-006 Port rst_n, input, 1, asynchronous active-low reset.
REQ-007 Port in_valid, input, 1, operation offered.
REQ-008 Port in_ready, output, 1, operation accepted on an edge where in_valid=1 and in_ready=1.
REQ-009 Ports Reg1, Reg2, input, WIDTH each, operands.
REQ-010 Port IV, input, IMM_W, immediate and shift amount.
REQ-011 Port OpCode, input, 4: 0 ADD, 1 SUB, 2 MUL, 3 OR, 4 AND, 5 XOR, 6 MOVn (immediate), 7 MOV, 8 LSR, 9 LSL, A ROR, B CMP, C-F illegal.
REQ-012 Port Cond, input, 4: 0 EQ, 1 NE, 2 CS, 3 CC, 4 MI, 5 PL, 6 VS, 7 VC, 8 HI, 9 LS, A GE, B LT, C GT, D LE, E AL, F NV.
REQ-013 Port S, input, 1, update flags.
REQ-014 Ports out_valid output 1 and out_ready input 1; out_valid, Result (WIDTH), res_we (1, destination write), skipped (1, condition failed) and illegal (1) form one result beat.
REQ-015 Port Flag, output, 4, architectural NZCV register, N in bit 3.

Function
REQ-016 SHALL evaluate Cond against the internal NZCV register at acceptance, using ARM semantics; on failure, the beat SHALL carry skipped=1, res_we=0, Result=0, and flags unchanged.
REQ-017 States: IDLE, MUL_BUSY, HOLD. in_ready=1 only in IDLE, or in HOLD when out_ready=1 (back-to-back issue).
REQ-018 Non-MUL op accepted at edge T: out_valid=1 after edge T; state goes to HOLD.
REQ-019 MUL accepted at edge T: enter MUL_BUSY; iterative shift-add; out_valid=1 after edge T+WIDTH/MUL_RADIX_BITS; Result is the low WIDTH bits of the product.
REQ-020 HOLD: the beat stays stable while out_ready=0; with out_ready=1, go to IDLE, or accept a new op on the same edge.
REQ-021 Shifts: amount = IV[log2(WIDTH)-1:0]; ROR wraps modulo WIDTH; operand is Reg2.
REQ-022 MOVn: Result = IV zero-extended; MOV: Result = Reg2.
REQ-023 Flags (when S=1, or always for CMP): N=Result MSB; Z=(Result==0).
REQ-024 C flag: ADD carry-out; SUB/CMP not-borrow (unsigned Reg1>=Reg2); shifts take the last bit shifted out; shift amount 0, logic, MOV and MUL leave C unchanged.
REQ-025 V flag: signed overflow for ADD/SUB/CMP; unchanged otherwise.
REQ-026 CMP: res_we=0; Result = Reg1-Reg2 (informational).
REQ-027 Illegal opcode: single-cycle beat with illegal=1, res_we=0, Result=0, and flags unchanged.
REQ-028 The flag register SHALL update on the edge the result is registered, so the next accepted op's Cond sees the new flags.
REQ-029 All arithmetic SHALL be modulo 2^WIDTH; operands are treated as two's complement for N and V.

Reset
REQ-030 rst_n low SHALL force the state to IDLE, out_valid=0, Result=0, res_we=0, skipped=0, illegal=0, Flag=0, and clear the multiplier accumulator and counter.
REQ-031 While rst_n is low, in_ready SHALL be 0.
REQ-032 Reset during MUL_BUSY or HOLD SHALL abandon the op with no beat delivered; the first in_ready=1 SHALL occur after the first edge following deassertion.

Structure
REQ-033 The shared package alu_pkg SHALL hold the opcode and cond enums, the NZCV bit indices and the state enum.
REQ-034 The iterative multiplier SHALL be one sub-module, seq_mul (start/done handshake, parametrised by WIDTH and MUL_RADIX_BITS); everything else SHALL be inline.

Verification
REQ-035 ADD with S=1, Reg1=0x7FFFFFFF, Reg2=1, Cond=AL -> Result=0x80000000, Flag=1001 (N,V), one-cycle latency.
REQ-036 SUB with S=1, 5-5, then ADD with Cond=EQ, 2+3 -> first sets Z and C (Flag=0110); second executes, Result=5, res_we=1.
REQ-037 CMP 3 vs 7, then MOV with Cond=GE -> Flag=1000; MOV skipped=1, res_we=0.
REQ-038 MUL 0xFFFFFFFF*0xFFFFFFFF, WIDTH=32, radix 1 -> Result=1 after 32 cycles; out_ready held low 5 cycles -> beat stable, in_ready=0.
REQ-039 ROR Reg2=0x00000001, IV=1, S=1 -> Result=0x80000000, C=1; LSL with IV=0 -> C unchanged.
REQ-040 rst_n pulsed mid-MUL -> no beat; Flag=0; a following ADD completes normally; OpCode=0xD -> illegal=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode/condition encodings, flag bit
// positions, control states and the ARM-style condition evaluator.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_MUL  = 4'h2,
    OP_OR   = 4'h3,
    OP_AND  = 4'h4,
    OP_XOR  = 4'h5,
    OP_MOVN = 4'h6,
    OP_MOV  = 4'h7,
    OP_LSR  = 4'h8,
    OP_LSL  = 4'h9,
    OP_ROR  = 4'hA,
    OP_CMP  = 4'hB
  } opcode_e;

  typedef enum logic [3:0] {
    CC_EQ = 4'h0,
    CC_NE = 4'h1,
    CC_CS = 4'h2,
    CC_CC = 4'h3,
    CC_MI = 4'h4,
    CC_PL = 4'h5,
    CC_VS = 4'h6,
    CC_VC = 4'h7,
    CC_HI = 4'h8,
    CC_LS = 4'h9,
    CC_GE = 4'hA,
    CC_LT = 4'hB,
    CC_GT = 4'hC,
    CC_LE = 4'hD,
    CC_AL = 4'hE,
    CC_NV = 4'hF
  } cond_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_HOLD     = 2'd2
  } state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // NV never executes, matching the ARM "never" encoding.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n;
    logic z;
    logic c;
    logic v;
    logic ok;
    n = nzcv[FLAG_N];
    z = nzcv[FLAG_Z];
    c = nzcv[FLAG_C];
    v = nzcv[FLAG_V];
    case (cond)
      CC_EQ:   ok = z;
      CC_NE:   ok = ~z;
      CC_CS:   ok = c;
      CC_CC:   ok = ~c;
      CC_MI:   ok = n;
      CC_PL:   ok = ~n;
      CC_VS:   ok = v;
      CC_VC:   ok = ~v;
      CC_HI:   ok = c & ~z;
      CC_LS:   ok = ~c | z;
      CC_GE:   ok = (n == v);
      CC_LT:   ok = (n != v);
      CC_GT:   ok = ~z & (n == v);
      CC_LE:   ok = z | (n != v);
      CC_AL:   ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/seq_mul.sv
// Iterative shift-add multiplier retiring MUL_RADIX_BITS multiplier bits per
// cycle; done_o/product_o present the final partial sum on the last cycle.
module seq_mul #(
  parameter int WIDTH          = 32,
  parameter int MUL_RADIX_BITS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int STEPS = WIDTH / MUL_RADIX_BITS;
  localparam int CNT_W = $clog2(STEPS + 1);

  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] partial_s;
  logic [WIDTH-1:0] sum_s;

  // Partial product of the multiplicand and the current multiplier digit.
  always_comb begin
    partial_s = {WIDTH{1'b0}};
    for (int i = 0; i < MUL_RADIX_BITS; i++) begin
      if (mplier_q[i]) begin
        partial_s = partial_s + (mcand_q << i);
      end else begin
        partial_s = partial_s;
      end
    end
  end

  assign sum_s     = acc_q + partial_s;
  assign done_o    = busy_q & (cnt_q == CNT_W'(1'b1));
  assign product_o = sum_s;

  // Iteration registers; start reloads the operands and clears the accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
      acc_q    <= {WIDTH{1'b0}};
      mcand_q  <= {WIDTH{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
    end else if (start_i) begin
      busy_q   <= 1'b1;
      cnt_q    <= CNT_W'(STEPS);
      acc_q    <= {WIDTH{1'b0}};
      mcand_q  <= a_i;
      mplier_q <= b_i;
    end else if (busy_q) begin
      busy_q   <= (cnt_q != CNT_W'(1'b1));
      cnt_q    <= cnt_q - CNT_W'(1'b1);
      acc_q    <= sum_s;
      mcand_q  <= mcand_q << MUL_RADIX_BITS;
      mplier_q <= mplier_q >> MUL_RADIX_BITS;
    end else begin
      busy_q   <= busy_q;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Conditionally executed ALU with NZCV flags, a valid/ready issue port and a
// held result beat; MUL runs on the iterative seq_mul, everything else in one cycle.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int IMM_W          = 16,
  parameter int MUL_RADIX_BITS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Reg1,
  input  logic [WIDTH-1:0] Reg2,
  input  logic [IMM_W-1:0] IV,
  input  logic [3:0]       OpCode,
  input  logic [3:0]       Cond,
  input  logic             S,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             res_we,
  output logic             skipped,
  output logic             illegal,
  output logic [3:0]       Flag
);

  localparam int SH_W = $clog2(WIDTH);
  localparam int MSB  = WIDTH - 1;

  state_e           state_q, state_d;
  logic             rdy_en_q;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             res_we_q, res_we_d;
  logic             skipped_q, skipped_d;
  logic             illegal_q, illegal_d;
  logic [3:0]       flag_q, flag_d;
  logic             mul_s_q, mul_s_d;

  logic             in_ready_s;
  logic             accept_s;
  logic             illegal_op_s;
  logic             cond_ok_s;
  logic             mul_start_s;
  logic             mul_done_s;
  logic [WIDTH-1:0] mul_prod_s;

  logic [WIDTH-1:0] iv_ext_s;
  logic [SH_W-1:0]  amt_s;
  logic [SH_W-1:0]  idx_r_s;
  logic [SH_W-1:0]  idx_l_s;
  logic [SH_W:0]    rol_amt_s;
  logic [WIDTH:0]   add_s;
  logic [WIDTH-1:0] sub_s;
  logic [WIDTH-1:0] ror_s;

  logic [WIDTH-1:0] alu_res_s;
  logic             alu_c_s;
  logic             alu_v_s;
  logic             alu_we_s;
  logic             alu_fl_s;

  seq_mul #(
    .WIDTH         (WIDTH),
    .MUL_RADIX_BITS(MUL_RADIX_BITS)
  ) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (mul_start_s),
    .a_i      (Reg1),
    .b_i      (Reg2),
    .done_o   (mul_done_s),
    .product_o(mul_prod_s)
  );

  assign iv_ext_s  = WIDTH'(IV);
  assign amt_s     = iv_ext_s[SH_W-1:0];
  // Index of the last bit shifted out: amt-1 for right shifts, WIDTH-amt for left.
  assign idx_r_s   = amt_s - SH_W'(1'b1);
  assign idx_l_s   = {SH_W{1'b0}} - amt_s;
  assign rol_amt_s = (SH_W + 1)'(WIDTH) - {1'b0, amt_s};
  assign add_s     = {1'b0, Reg1} + {1'b0, Reg2};
  assign sub_s     = Reg1 - Reg2;
  assign ror_s     = (Reg2 >> amt_s) | (Reg2 << rol_amt_s);

  // rdy_en_q keeps in_ready low until the first edge after reset release.
  assign in_ready_s   = rdy_en_q & ((state_q == ST_IDLE) | ((state_q == ST_HOLD) & out_ready));
  assign accept_s     = in_valid & in_ready_s;
  assign illegal_op_s = (OpCode >= 4'hC);
  assign cond_ok_s    = cond_pass(Cond, flag_q);

  // Single-cycle datapath: result, carry/overflow candidates and write enable.
  always_comb begin
    alu_res_s = {WIDTH{1'b0}};
    alu_c_s   = flag_q[FLAG_C];
    alu_v_s   = flag_q[FLAG_V];
    alu_we_s  = 1'b1;
    alu_fl_s  = S;
    case (OpCode)
      OP_ADD: begin
        alu_res_s = add_s[MSB:0];
        alu_c_s   = add_s[WIDTH];
        alu_v_s   = (Reg1[MSB] == Reg2[MSB]) & (add_s[MSB] != Reg1[MSB]);
      end
      OP_SUB: begin
        alu_res_s = sub_s;
        alu_c_s   = (Reg1 >= Reg2);
        alu_v_s   = (Reg1[MSB] != Reg2[MSB]) & (sub_s[MSB] != Reg1[MSB]);
      end
      OP_CMP: begin
        alu_res_s = sub_s;
        alu_c_s   = (Reg1 >= Reg2);
        alu_v_s   = (Reg1[MSB] != Reg2[MSB]) & (sub_s[MSB] != Reg1[MSB]);
        alu_we_s  = 1'b0;
        alu_fl_s  = 1'b1;
      end
      OP_MUL:  alu_res_s = {WIDTH{1'b0}};
      OP_OR:   alu_res_s = Reg1 | Reg2;
      OP_AND:  alu_res_s = Reg1 & Reg2;
      OP_XOR:  alu_res_s = Reg1 ^ Reg2;
      OP_MOVN: alu_res_s = iv_ext_s;
      OP_MOV:  alu_res_s = Reg2;
      OP_LSR: begin
        alu_res_s = Reg2 >> amt_s;
        if (amt_s != {SH_W{1'b0}}) begin
          alu_c_s = Reg2[idx_r_s];
        end else begin
          alu_c_s = flag_q[FLAG_C];
        end
      end
      OP_LSL: begin
        alu_res_s = Reg2 << amt_s;
        if (amt_s != {SH_W{1'b0}}) begin
          alu_c_s = Reg2[idx_l_s];
        end else begin
          alu_c_s = flag_q[FLAG_C];
        end
      end
      OP_ROR: begin
        alu_res_s = ror_s;
        if (amt_s != {SH_W{1'b0}}) begin
          alu_c_s = ror_s[MSB];
        end else begin
          alu_c_s = flag_q[FLAG_C];
        end
      end
      default: begin
        alu_we_s = 1'b0;
        alu_fl_s = 1'b0;
      end
    endcase
  end

  // Control: beat retirement per state, then launch of a newly accepted op.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    res_we_d    = res_we_q;
    skipped_d   = skipped_q;
    illegal_d   = illegal_q;
    flag_d      = flag_q;
    mul_s_d     = mul_s_q;
    mul_start_s = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_MUL_BUSY: begin
        if (mul_done_s) begin
          out_valid_d = 1'b1;
          result_d    = mul_prod_s;
          res_we_d    = 1'b1;
          skipped_d   = 1'b0;
          illegal_d   = 1'b0;
          state_d     = ST_HOLD;
          if (mul_s_q) begin
            flag_d = {mul_prod_s[MSB], (mul_prod_s == {WIDTH{1'b0}}),
                      flag_q[FLAG_C], flag_q[FLAG_V]};
          end else begin
            flag_d = flag_q;
          end
        end else begin
          state_d = ST_MUL_BUSY;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase

    if (accept_s) begin
      if (illegal_op_s) begin
        out_valid_d = 1'b1;
        result_d    = {WIDTH{1'b0}};
        res_we_d    = 1'b0;
        skipped_d   = 1'b0;
        illegal_d   = 1'b1;
        state_d     = ST_HOLD;
      end else if (!cond_ok_s) begin
        out_valid_d = 1'b1;
        result_d    = {WIDTH{1'b0}};
        res_we_d    = 1'b0;
        skipped_d   = 1'b1;
        illegal_d   = 1'b0;
        state_d     = ST_HOLD;
      end else if (OpCode == OP_MUL) begin
        mul_start_s = 1'b1;
        mul_s_d     = S;
        out_valid_d = 1'b0;
        state_d     = ST_MUL_BUSY;
      end else begin
        out_valid_d = 1'b1;
        result_d    = alu_res_s;
        res_we_d    = alu_we_s;
        skipped_d   = 1'b0;
        illegal_d   = 1'b0;
        state_d     = ST_HOLD;
        if (alu_fl_s) begin
          flag_d = {alu_res_s[MSB], (alu_res_s == {WIDTH{1'b0}}), alu_c_s, alu_v_s};
        end else begin
          flag_d = flag_q;
        end
      end
    end else begin
      mul_start_s = 1'b0;
    end
  end

  // State, beat and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rdy_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= {WIDTH{1'b0}};
      res_we_q    <= 1'b0;
      skipped_q   <= 1'b0;
      illegal_q   <= 1'b0;
      flag_q      <= 4'b0000;
      mul_s_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdy_en_q    <= 1'b1;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      res_we_q    <= res_we_d;
      skipped_q   <= skipped_d;
      illegal_q   <= illegal_d;
      flag_q      <= flag_d;
      mul_s_q     <= mul_s_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign Result    = result_q;
  assign res_we    = res_we_q;
  assign skipped   = skipped_q;
  assign illegal   = illegal_q;
  assign Flag      = flag_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=32, radix 1): an arithmetic reference model
// feeds a scoreboard checked every cycle, plus hand-computed literal checks.
module tb_seq_alu;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] Reg1;
  logic [31:0] Reg2;
  logic [15:0] IV;
  logic [3:0]  OpCode;
  logic [3:0]  Cond;
  logic        S;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Result;
  logic        res_we;
  logic        skipped;
  logic        illegal;
  logic [3:0]  Flag;

  seq_alu dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .Reg1(Reg1), .Reg2(Reg2), .IV(IV), .OpCode(OpCode), .Cond(Cond), .S(S),
    .out_valid(out_valid), .out_ready(out_ready), .Result(Result),
    .res_we(res_we), .skipped(skipped), .illegal(illegal), .Flag(Flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        we;
    logic        sk;
    logic        il;
    logic [3:0]  fl;
    int          lat;
    time         ta;
  } exp_t;

  exp_t       q[$];
  bit         front_seen;
  logic [3:0] mdl_flag;
  int         tot;
  int         errs;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: ARM condition table and plain integer arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [3:0] cond, input logic s,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [15:0] iv, input logic [3:0] fl);
    exp_t e;
    logic n, z, c, v, pass, upd;
    longint ss;
    logic [63:0] wide;
    logic [31:0] t;
    int amt;
    n = fl[3]; z = fl[2]; c = fl[1]; v = fl[0];
    e.res = 32'h0; e.we = 1'b0; e.sk = 1'b0; e.il = 1'b0; e.fl = fl; e.lat = 0; e.ta = 0;
    case (cond)
      4'h0: pass = z;          4'h1: pass = !z;
      4'h2: pass = c;          4'h3: pass = !c;
      4'h4: pass = n;          4'h5: pass = !n;
      4'h6: pass = v;          4'h7: pass = !v;
      4'h8: pass = c && !z;    4'h9: pass = !c || z;
      4'hA: pass = (n == v);   4'hB: pass = (n != v);
      4'hC: pass = !z && (n == v);
      4'hD: pass = z || (n != v);
      4'hE: pass = 1'b1;
      default: pass = 1'b0;
    endcase
    if (op >= 4'hC) begin e.il = 1'b1; return e; end
    if (!pass) begin e.sk = 1'b1; return e; end
    upd = s; e.we = 1'b1; amt = int'(iv[4:0]); t = b;
    case (op)
      4'h0: begin
        wide = {32'h0, a} + {32'h0, b};
        e.res = wide[31:0];
        c = (wide > 64'h0000_0000_FFFF_FFFF);
        ss = longint'($signed(a)) + longint'($signed(b));
        v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      4'h1, 4'hB: begin
        e.res = a - b;
        c = (a >= b);
        ss = longint'($signed(a)) - longint'($signed(b));
        v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
        if (op == 4'hB) begin e.we = 1'b0; upd = 1'b1; end
      end
      4'h2: begin wide = {32'h0, a} * {32'h0, b}; e.res = wide[31:0]; e.lat = 32; end
      4'h3: e.res = a | b;
      4'h4: e.res = a & b;
      4'h5: e.res = a ^ b;
      4'h6: e.res = {16'h0, iv};
      4'h7: e.res = b;
      4'h8: begin for (int k = 0; k < amt; k++) begin c = t[0]; t = t >> 1; end e.res = t; end
      4'h9: begin for (int k = 0; k < amt; k++) begin c = t[31]; t = t << 1; end e.res = t; end
      default: begin for (int k = 0; k < amt; k++) begin c = t[0]; t = {t[0], t[31:1]}; end e.res = t; end
    endcase
    if (upd) e.fl = {e.res[31], (e.res == 32'h0), c, v};
    return e;
  endfunction

  task automatic issue(input logic [3:0] op, input logic [3:0] cond, input logic s,
                       input logic [31:0] a, input logic [31:0] b, input logic [15:0] iv);
    exp_t e;
    bit got;
    got = 1'b0;
    OpCode = op; Cond = cond; S = s; Reg1 = a; Reg2 = b; IV = iv; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (in_ready === 1'b1) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk("issue_accept", {63'h0, got}, 64'h1);
    if (!got) begin in_valid = 1'b0; return; end
    @(posedge clk);
    e = model(op, cond, s, a, b, iv, mdl_flag);
    e.ta = $time;
    mdl_flag = e.fl;
    q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Scoreboard compare, sampled 2 time units after each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n === 1'b0) begin
        chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("rst_in_ready", {63'h0, in_ready}, 64'h0);
        chk("rst_flag", {60'h0, Flag}, 64'h0);
        chk("rst_result", {32'h0, Result}, 64'h0);
      end else if (out_valid === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", 64'h1, 64'h0);
        end else begin
          chk("beat_result", {32'h0, Result}, {32'h0, q[0].res});
          chk("beat_res_we", {63'h0, res_we}, {63'h0, q[0].we});
          chk("beat_skipped", {63'h0, skipped}, {63'h0, q[0].sk});
          chk("beat_illegal", {63'h0, illegal}, {63'h0, q[0].il});
          chk("beat_flag", {60'h0, Flag}, {60'h0, q[0].fl});
          if (!front_seen) begin
            chk("beat_latency", 64'($time - 2 - q[0].ta), 64'(q[0].lat * 10 + 5));
            front_seen = 1'b1;
          end
          if (out_ready === 1'b1) begin
            void'(q.pop_front());
            front_seen = 1'b0;
          end
        end
      end else if (q.size() == 0) begin
        chk("idle_flag", {60'h0, Flag}, {60'h0, mdl_flag});
      end else if (!front_seen) begin
        chk("busy_in_ready", {63'h0, in_ready}, 64'h0);
      end
    end
  end

  logic [31:0] ca[4];
  logic [31:0] cb[4];
  exp_t        pin;
  bit          found;

  initial begin
    tot = 0; errs = 0; mdl_flag = 4'h0; front_seen = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    Reg1 = 32'h0; Reg2 = 32'h0; IV = 16'h0; OpCode = 4'h0; Cond = 4'hE; S = 1'b0;
    ca[0] = 32'd1;        cb[0] = 32'd1;
    ca[1] = 32'd1;        cb[1] = 32'd2;
    ca[2] = 32'h80000000; cb[2] = 32'd1;
    ca[3] = 32'h7FFFFFFF; cb[3] = 32'hFFFFFFFF;

    pin = model(4'h0, 4'hE, 1'b1, 32'h7FFFFFFF, 32'd1, 16'h0, 4'h0);
    chk("pin_add_res", {32'h0, pin.res}, 64'h80000000);
    chk("pin_add_flag", {60'h0, pin.fl}, 64'h9);
    pin = model(4'h2, 4'hE, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'h0, 4'h0);
    chk("pin_mul_res", {32'h0, pin.res}, 64'h1);
    pin = model(4'hA, 4'hE, 1'b1, 32'h1, 32'h1, 16'h1, 4'h0);
    chk("pin_ror_flag", {60'h0, pin.fl}, 64'hA);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_after_release", {63'h0, in_ready}, 64'h0);
    @(negedge clk);
    #1 chk("ready_after_edge", {63'h0, in_ready}, 64'h1);

    issue(4'h0, 4'hE, 1'b1, 32'h7FFFFFFF, 32'h1, 16'h0);
    #1 chk("add_ovf_result", {32'h0, Result}, 64'h80000000);
    chk("add_ovf_flag", {60'h0, Flag}, 64'h9);
    issue(4'h1, 4'hE, 1'b1, 32'd5, 32'd5, 16'h0);
    #1 chk("sub_zero_flag", {60'h0, Flag}, 64'h6);
    issue(4'h0, 4'h0, 1'b0, 32'd2, 32'd3, 16'h0);
    #1 chk("add_eq_result", {32'h0, Result}, 64'h5);
    chk("add_eq_we", {63'h0, res_we}, 64'h1);
    issue(4'hB, 4'hE, 1'b0, 32'd3, 32'd7, 16'h0);
    #1 chk("cmp_flag", {60'h0, Flag}, 64'h8);
    chk("cmp_we", {63'h0, res_we}, 64'h0);
    issue(4'h7, 4'hA, 1'b0, 32'd1, 32'd9, 16'h0);
    #1 chk("mov_ge_skipped", {63'h0, skipped}, 64'h1);
    chk("mov_ge_we", {63'h0, res_we}, 64'h0);
    issue(4'hA, 4'hE, 1'b1, 32'h0, 32'h1, 16'h1);
    #1 chk("ror_result", {32'h0, Result}, 64'h80000000);
    chk("ror_carry", {63'h0, Flag[1]}, 64'h1);
    issue(4'h9, 4'hE, 1'b1, 32'h0, 32'h5, 16'h0);
    #1 chk("lsl0_carry_kept", {63'h0, Flag[1]}, 64'h1);

    issue(4'h8, 4'hE, 1'b1, 32'h0, 32'h80000001, 16'h1);
    issue(4'h9, 4'hE, 1'b1, 32'h0, 32'h40000000, 16'h1);
    issue(4'h9, 4'hE, 1'b1, 32'h0, 32'hC0000000, 16'h1);
    issue(4'h1, 4'hE, 1'b1, 32'h80000000, 32'h1, 16'h0);
    issue(4'h3, 4'hE, 1'b1, 32'hF0F00000, 32'h0000F0F0, 16'h0);
    issue(4'h4, 4'hE, 1'b1, 32'hF0F0F0F0, 32'h0F0F0F0F, 16'h0);
    issue(4'h5, 4'hE, 1'b1, 32'hFFFF0000, 32'h0000FFFF, 16'h0);
    issue(4'h6, 4'hE, 1'b1, 32'h0, 32'h0, 16'hABCD);
    issue(4'hA, 4'hE, 1'b1, 32'h0, 32'h00000003, 16'd33);
    issue(4'h8, 4'hE, 1'b1, 32'h0, 32'h80000000, 16'd31);
    issue(4'h0, 4'hE, 1'b1, 32'hFFFFFFFF, 32'h1, 16'h0);
    issue(4'h2, 4'hF, 1'b0, 32'd3, 32'd4, 16'h0);

    for (int c = 0; c < 16; c++) begin
      issue(4'hB, 4'hE, 1'b0, ca[c % 4], cb[c % 4], 16'h0);
      issue(4'h0, 4'(c), 1'b0, 32'(c), 32'd100, 16'h0);
    end

    issue(4'h2, 4'hE, 1'b1, 32'd7, 32'd6, 16'h0);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (out_valid === 1'b1) begin found = 1'b1; break; end
      @(negedge clk);
    end
    chk("mul_small_done", {63'h0, found}, 64'h1);
    chk("mul_small_result", {32'h0, Result}, 64'd42);

    @(negedge clk);
    out_ready = 1'b0;
    issue(4'h2, 4'hE, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'h0);
    #1 chk("mul_busy_ready", {63'h0, in_ready}, 64'h0);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (out_valid === 1'b1) begin found = 1'b1; break; end
      @(negedge clk);
    end
    chk("mul_big_done", {63'h0, found}, 64'h1);
    for (int i = 0; i < 5; i++) begin
      chk("hold_result", {32'h0, Result}, 64'h1);
      chk("hold_valid", {63'h0, out_valid}, 64'h1);
      chk("hold_in_ready", {63'h0, in_ready}, 64'h0);
      @(negedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);

    issue(4'hD, 4'hE, 1'b1, 32'd1, 32'd1, 16'h0);
    #1 chk("illegal_d_flag", {63'h0, illegal}, 64'h1);
    chk("illegal_d_we", {63'h0, res_we}, 64'h0);

    issue(4'h2, 4'hE, 1'b1, 32'd9, 32'd9, 16'h0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    front_seen = 1'b0;
    mdl_flag = 4'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_after_rerelease", {63'h0, in_ready}, 64'h0);
    repeat (40) begin
      chk("no_beat_after_abort", {63'h0, out_valid}, 64'h0);
      @(negedge clk);
      #1;
    end
    chk("flag_after_reset", {60'h0, Flag}, 64'h0);

    issue(4'h0, 4'hE, 1'b0, 32'd2, 32'd3, 16'h0);
    #1 chk("add_after_reset", {32'h0, Result}, 64'h5);
    issue(4'hD, 4'hE, 1'b0, 32'd2, 32'd3, 16'h0);
    #1 chk("illegal_after_reset", {63'h0, illegal}, 64'h1);
    issue(4'hF, 4'hE, 1'b1, 32'd0, 32'd0, 16'h0);
    #1 chk("illegal_f_result", {32'h0, Result}, 64'h0);

    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    @(negedge clk);
    #3;
    chk("queue_drained", 64'(q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errs, tot);
    $finish;
  end

endmodule
